// File: rtl/tm1638_frame_tx_if.sv
// tm1638_frame_tx_if: valid/ready byte stream feeding the TM1638 frame transmitter
interface tm1638_frame_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] s_data;
  logic s_valid;
  logic s_last;
  logic s_ready;
  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/tm1638_frame_tx.sv
// tm1638_frame_tx: TM1638 CLK/STB/DIO frame generator fed by a valid/ready stream, s_last closes the frame.
// Define TM1638_TX_MSB_FIRST_EN to shift MSB first; default is LSB first.
module tm1638_frame_tx #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 8
) (
  input  logic mclk,
  input  logic rst_n,
  tm1638_frame_tx_if.slave s,
  output logic tm_clk,
  output logic tm_stb,
  output logic dio_out,
  output logic dio_oe,
  output logic busy,
  output logic frame_done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, TAIL, HOLD} state_t;
  state_t state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic phase, phase_n;
  logic [DATA_W-1:0] shift_reg, src, sel;
  logic last_q, ready_q, xfer, div_end, bit_val;
  logic clk_n, stb_n, dio_n, ready_n, busy_n, done_n;
  assign s.s_ready = ready_q;
  assign xfer = s.s_valid & ready_q;
  assign div_end = div_cnt == DIV_MAX;
  // a byte accepted in GAP must drive its first bit in the very next cycle
  assign src = xfer ? s.s_data : shift_reg;
`ifdef TM1638_TX_MSB_FIRST_EN
  assign sel = src << bit_n;
  assign bit_val = sel[DATA_W-1];
`else
  assign sel = src >> bit_n;
  assign bit_val = sel[0];
`endif
  always_comb begin
    state_n = state;
    div_n = div_cnt + 1'b1;
    bit_n = bit_cnt;
    phase_n = phase;
    case (state)
      IDLE: begin
        div_n = '0;
        if (xfer) state_n = SETUP;
      end
      SETUP: if (div_end) begin
        state_n = SHIFT;
        div_n = '0;
        bit_n = '0;
        phase_n = 1'b0;
      end
      SHIFT: if (div_end) begin
        div_n = '0;
        phase_n = !phase;
        if (phase) begin
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_MAX) begin
            state_n = last_q ? TAIL : GAP;
            bit_n = '0;
          end
        end
      end
      GAP: begin
        div_n = '0;
        if (xfer) begin
          state_n = SHIFT;
          bit_n = '0;
          phase_n = 1'b0;
        end
      end
      TAIL: if (div_end) begin
        state_n = HOLD;
        div_n = '0;
      end
      HOLD: if (div_end) begin
        state_n = IDLE;
        div_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state and registered so the pins never glitch
  assign clk_n = !(state_n == SHIFT && !phase_n);
  assign stb_n = state_n == IDLE || state_n == HOLD;
  assign dio_n = state_n == SHIFT ? bit_val : (state_n == GAP || state_n == TAIL) ? dio_out : 1'b1;
  assign ready_n = state_n == IDLE || (state == GAP && state_n == GAP);
  assign busy_n = state_n != IDLE;
  assign done_n = state == HOLD && state_n == IDLE;
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase <= 1'b0;
      shift_reg <= '0;
      last_q <= 1'b0;
      ready_q <= 1'b0;
      tm_clk <= 1'b1;
      tm_stb <= 1'b1;
      dio_out <= 1'b1;
      dio_oe <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      phase <= phase_n;
      if (xfer) begin
        shift_reg <= s.s_data;
        last_q <= s.s_last;
      end
      ready_q <= ready_n;
      tm_clk <= clk_n;
      tm_stb <= stb_n;
      dio_out <= dio_n;
      dio_oe <= !stb_n;
      busy <= busy_n;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_tm1638_frame_tx.sv
// tb_tm1638_frame_tx: directed checks of the TM1638 frame transmitter (DATA_W=8, CLK_DIV=2).
module tb_tm1638_frame_tx;
  localparam int DATA_W = 8;
  localparam int CLK_DIV = 2;
  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  logic tm_clk, tm_stb, dio_out, dio_oe, busy, frame_done;
  tm1638_frame_tx_if #(.DATA_W(DATA_W)) bus ();
  tm1638_frame_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .mclk(mclk), .rst_n(rst_n), .s(bus),
    .tm_clk(tm_clk), .tm_stb(tm_stb), .dio_out(dio_out), .dio_oe(dio_oe),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 mclk = ~mclk;
  int vectors = 0;
  int fails = 0;
  logic [31:0] obs_bits;
  int nbits, nrise, stb_low, done_cnt, hi_run, last_gap, ready_bad;
  logic prev_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_word(input logic [7:0] d);
    logic [7:0] r;
`ifdef TM1638_TX_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
    r = d;
`endif
    return r;
  endfunction
  task automatic step();
    @(posedge mclk);
    #1;
    if (prev_clk && !tm_clk) begin
      if (nbits < 32) obs_bits[nbits] = dio_out;
      nbits++;
    end
    if (!prev_clk && tm_clk && !tm_stb) nrise++;
    if (!tm_stb) stb_low++;
    if (frame_done) done_cnt++;
    if (tm_stb) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (bus.s_ready && !(tm_clk && (!tm_stb || !busy))) ready_bad++;
    prev_clk = tm_clk;
  endtask
  task automatic clear();
    obs_bits = '0;
    nbits = 0;
    nrise = 0;
    stb_low = 0;
    done_cnt = 0;
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    bus.s_data = d;
    bus.s_last = last;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 300) begin
      step();
      n++;
    end
    check("send_accept", 32'(n < 300), 32'd1);
    step();
    bus.s_valid = 1'b0;
  endtask
  task automatic finish_frame();
    int n = 0;
    while (!frame_done && n < 500) begin
      step();
      n++;
    end
    check("frame_done_seen", 32'(n < 500), 32'd1);
  endtask
  task automatic idle_check(input string tag);
    check({tag, "_clk"}, 32'(tm_clk), 32'd1);
    check({tag, "_stb"}, 32'(tm_stb), 32'd1);
    check({tag, "_dio"}, 32'(dio_out), 32'd1);
    check({tag, "_oe"}, 32'(dio_oe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    int n;
    int stall_bad;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    prev_clk = 1'b1;
    hi_run = 0;
    last_gap = 0;
    ready_bad = 0;
    clear();
    repeat (3) @(posedge mclk);
    #1;
    idle_check("reset");
    check("reset_ready", 32'(bus.s_ready), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    // single byte frame and exact start-up timing
    clear();
    send(8'h8F, 1'b1);
    check("t1_stb_low", 32'(tm_stb), 32'd0);
    check("t1_oe", 32'(dio_oe), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_setup", 32'(bus.s_ready), 32'd0);
    check("t1_clk_setup", 32'(tm_clk), 32'd1);
    step();
    check("t1_clk_setup2", 32'(tm_clk), 32'd1);
    step();
    check("t1_first_fall", 32'(tm_clk), 32'd0);
    check("t1_first_bit", 32'(dio_out), 32'(exp_word(8'h8F) & 8'h01));
    finish_frame();
    check("t1_nbits", 32'(nbits), 32'd8);
    check("t1_bits", obs_bits, 32'(exp_word(8'h8F)));
    check("t1_stb_cycles", 32'(stb_low), 32'd36);
    idle_check("t1_end");
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    step();
    check("t1_done_pulse", 32'(frame_done), 32'd0);
    // three back-to-back bytes in one STB window
    clear();
    send(8'h40, 1'b0);
    send(8'hC0, 1'b0);
    send(8'h3F, 1'b1);
    finish_frame();
    check("t2_nbits", 32'(nbits), 32'd24);
    check("t2_bits", obs_bits, {8'h00, exp_word(8'h3F), exp_word(8'hC0), exp_word(8'h40)});
    check("t2_rises", 32'(nrise), 32'd24);
    check("t2_stb_cycles", 32'(stb_low), 32'd104);
    // stalled GAP between bytes
    clear();
    send(8'hC0, 1'b0);
    n = 0;
    while (!bus.s_ready && n < 300) begin
      step();
      n++;
    end
    check("t3_gap_ready", 32'(bus.s_ready), 32'd1);
    stall_bad = 0;
    repeat (20) begin
      step();
      if (!(tm_clk === 1'b1 && tm_stb === 1'b0 && bus.s_ready === 1'b1)) stall_bad++;
    end
    check("t3_stall_lines", 32'(stall_bad), 32'd0);
    send(8'h06, 1'b1);
    finish_frame();
    check("t3_nbits", 32'(nbits), 32'd16);
    check("t3_bits", obs_bits, {16'h0000, exp_word(8'h06), exp_word(8'hC0)});
    check("t3_stb_cycles", 32'(stb_low), 32'd90);
    step();
    // asynchronous reset in the middle of byte 2
    clear();
    send(8'h40, 1'b0);
    send(8'hC0, 1'b0);
    repeat (5) step();
    check("t4_pre_clk_low", 32'(tm_clk), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    idle_check("t4_reset");
    check("t4_ready", 32'(bus.s_ready), 32'd0);
    @(negedge mclk);
    rst_n = 1'b1;
    prev_clk = tm_clk;
    repeat (2) step();
    clear();
    send(8'h8F, 1'b1);
    finish_frame();
    check("t4_nbits", 32'(nbits), 32'd8);
    check("t4_bits", obs_bits, 32'(exp_word(8'h8F)));
    check("t4_stb_cycles", 32'(stb_low), 32'd36);
    step();
    // two single-byte frames with s_valid held high
    clear();
    ready_bad = 0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    check("t5_interframe", 32'(last_gap), 32'd3);
    finish_frame();
    check("t5_nbits", 32'(nbits), 32'd16);
    check("t5_bits", obs_bits, {16'h0000, exp_word(8'h02), exp_word(8'h01)});
    check("t5_done_cnt", 32'(done_cnt), 32'd2);
    check("t5_ready_outside", 32'(ready_bad), 32'd0);
    idle_check("t5_end");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
